// File: rtl/tx_rr_arbiter.sv
// Round-robin scheduler sharing one serial transmitter between N collector channels.
// Grants one requester, pulses tx_start, and holds the grant until tx_done or watchdog expiry.
module tx_rr_arbiter #(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            tx_done,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            tx_start,
    output logic            busy,
    output logic            timeout
);

    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]      state;
    logic [ID_W-1:0] ptr;
    logic [WDW-1:0]  wdog;

    logic            found;
    logic [ID_W-1:0] winner;
    logic [N-1:0]    win_onehot;
    logic [ID_W-1:0] next_ptr;
    int unsigned     idx;

    // Priority scan starting at ptr, wrapping modulo N (N need not be a power of two).
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
        next_ptr           = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
    end

    // Outputs are loaded on the transition into each state so they are valid
    // throughout that state's cycle(s) without any combinational decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            wdog     <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt_id   <= winner;
                        gnt      <= win_onehot;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    tx_start <= 1'b0;
                    wdog     <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (TIMEOUT != 0) wdog <= wdog + 1'b1;
                    if (tx_done) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_RELEASE;
                    end else if ((TIMEOUT != 0) && (wdog == WDOG_LAST)) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    timeout <= 1'b0;
                    ptr     <= next_ptr;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Directed bench for tx_rr_arbiter: three instances (default, short and disabled watchdog)
// with a queue of expected grant ids checked whenever tx_start appears.
module tb_tx_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] a_req = '0, b_req = '0, c_req = '0;
    logic       a_done = 1'b0, b_done = 1'b0, c_done = 1'b0;
    logic [3:0] a_gnt, b_gnt, c_gnt;
    logic [1:0] a_id, b_id, c_id;
    logic       a_start, b_start, c_start;
    logic       a_busy, b_busy, c_busy;
    logic       a_to, b_to, c_to;

    int nchk  = 0;
    int npass = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    tx_rr_arbiter #(.N(4), .ID_W(2), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .tx_done(a_done), .gnt(a_gnt), .gnt_id(a_id),
        .tx_start(a_start), .busy(a_busy), .timeout(a_to));

    tx_rr_arbiter #(.N(4), .ID_W(2), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .tx_done(b_done), .gnt(b_gnt), .gnt_id(b_id),
        .tx_start(b_start), .busy(b_busy), .timeout(b_to));

    tx_rr_arbiter #(.N(4), .ID_W(2), .TIMEOUT(0)) dut_c (
        .clk(clk), .rst(rst), .req(c_req), .tx_done(c_done), .gnt(c_gnt), .gnt_id(c_id),
        .tx_start(c_start), .busy(c_busy), .timeout(c_to));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Current cycle must be START of dut_a; winner comes from the scoreboard.
    task automatic expect_grant(input string tag);
        int e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_tx_start"}, 32'(a_start), 32'd1);
        chk({tag, "_gnt_id"}, 32'(a_id), 32'(e));
        chk({tag, "_gnt"}, 32'(a_gnt), 32'd1 << e);
        chk({tag, "_busy"}, 32'(a_busy), 32'd1);
    endtask

    // From START of dut_a: tx_done in WAIT cycle k, then land in IDLE.
    task automatic finish_a(input int k);
        repeat (k) tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("rel_gnt", 32'(a_gnt), 32'd0);
        chk("rel_busy", 32'(a_busy), 32'd0);
        tick();
    endtask

    initial begin
        int ids[6] = '{0, 1, 2, 3, 0, 2};
        bit to_seen;

        // Reset state
        tick();
        tick();
        chk("rst_gnt", 32'(a_gnt), 32'd0);
        chk("rst_id", 32'(a_id), 32'd0);
        chk("rst_start", 32'(a_start), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_to", 32'(a_to), 32'd0);
        rst = 1'b0;
        tick();

        // Single request, tx_done after 5 WAIT cycles
        a_req = 4'b0100;
        exp_q.push_back(2);
        tick();
        expect_grant("single");
        a_req = '0;
        tick();
        chk("single_start_pulse", 32'(a_start), 32'd0);
        chk("single_wait_gnt", 32'(a_gnt), 32'b0100);
        repeat (4) tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("single_rel_gnt", 32'(a_gnt), 32'd0);
        chk("single_rel_busy", 32'(a_busy), 32'd0);
        chk("single_rel_to", 32'(a_to), 32'd0);
        tick();
        // ptr must now be 3: with 1001 pending, channel 3 beats channel 0
        a_req = 4'b1001;
        exp_q.push_back(3);
        tick();
        expect_grant("ptr3");
        a_req = '0;
        finish_a(2);

        // Rotation 0,1,2,3 then wrap/fairness with 0101 -> 0 then 2
        a_req = 4'b1111;
        foreach (ids[g]) exp_q.push_back(ids[g]);
        tick();
        for (int g = 0; g < 6; g++) begin
            expect_grant("rot");
            tick();
            chk("rot_start_pulse", 32'(a_start), 32'd0);
            tick();
            tick();
            a_done = 1'b1;
            tick();
            a_done = 1'b0;
            if (g == 3) a_req = 4'b0101;
            if (g == 5) a_req = 4'b0000;
            chk("rot_gap1_busy", 32'(a_busy), 32'd0);
            tick();
            chk("rot_gap2_busy", 32'(a_busy), 32'd0);
            if (g < 5) begin
                tick();
                chk("rot_regrant_busy", 32'(a_busy), 32'd1);
            end
        end

        // Spurious tx_done in IDLE and START, then reset mid-WAIT
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("idle_done_busy", 32'(a_busy), 32'd0);
        chk("idle_done_gnt", 32'(a_gnt), 32'd0);
        a_req = 4'b0010;
        exp_q.push_back(1);
        tick();
        expect_grant("spur");
        a_req = '0;
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("start_done_busy", 32'(a_busy), 32'd1);
        chk("start_done_gnt", 32'(a_gnt), 32'b0010);
        tick();
        chk("start_done_busy2", 32'(a_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_gnt", 32'(a_gnt), 32'd0);
        chk("midrst_id", 32'(a_id), 32'd0);
        chk("midrst_start", 32'(a_start), 32'd0);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_to", 32'(a_to), 32'd0);
        a_req = 4'b1111;
        exp_q.push_back(0);
        tick();
        expect_grant("postrst");
        a_req = '0;
        finish_a(1);

        // Watchdog TIMEOUT=8: forced release 9 cycles after tx_start
        b_req = 4'b0001;
        tick();
        chk("wd_start", 32'(b_start), 32'd1);
        b_req = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 9) begin
                chk("wd_early_to", 32'(b_to), 32'd0);
                chk("wd_held_gnt", 32'(b_gnt), 32'b0001);
            end
        end
        chk("wd_to", 32'(b_to), 32'd1);
        chk("wd_gnt", 32'(b_gnt), 32'd0);
        chk("wd_busy", 32'(b_busy), 32'd0);
        tick();
        chk("wd_to_pulse", 32'(b_to), 32'd0);

        // Collision: tx_done on the expiry cycle wins
        b_req = 4'b0001;
        tick();
        chk("col_start", 32'(b_start), 32'd1);
        b_req = '0;
        repeat (8) tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        chk("col_gnt", 32'(b_gnt), 32'd0);
        chk("col_to", 32'(b_to), 32'd0);
        tick();

        // TIMEOUT=0: grant held indefinitely
        c_req = 4'b0001;
        tick();
        chk("nowd_start", 32'(c_start), 32'd1);
        c_req = '0;
        to_seen = 1'b0;
        repeat (1000) begin
            tick();
            if (c_to || !c_busy) to_seen = 1'b1;
        end
        chk("nowd_never_released", 32'(to_seen), 32'd0);
        chk("nowd_gnt", 32'(c_gnt), 32'b0001);
        c_done = 1'b1;
        tick();
        c_done = 1'b0;
        chk("nowd_rel_gnt", 32'(c_gnt), 32'd0);
        chk("nowd_rel_to", 32'(c_to), 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
